// File: rtl/ahbl_sram_resp.sv
// ---------------------------------------------------------------------------
// ahbl_sram_resp
//
// AHB-Lite subordinate fronting a single-port word RAM of 2^ADDR_WIDTH bytes.
// Legal transfers complete with OKAY after WAIT_STATES extra low-ready cycles.
// Byte and halfword writes use byte lanes. Misaligned or oversized transfers
// get a two-cycle ERROR response and never touch the RAM.
//
// Ports
//   clk_i             system clock
//   rstn              asynchronous active-low reset
//   ahbl_hsel_i       slave select from the address decoder
//   ahbl_haddr_i      byte address; bits above ADDR_WIDTH are ignored (alias)
//   ahbl_htrans_i     IDLE/BUSY/NONSEQ/SEQ (SEQ handled as NONSEQ)
//   ahbl_hwrite_i     1 = write
//   ahbl_hsize_i      0 byte, 1 half, 2 word; larger sizes are illegal
//   ahbl_hburst_i     ignored; every beat is treated as a single
//   ahbl_hready_i     bus-wide ready (previous data phase complete)
//   ahbl_hwdata_i     write data, sampled when the data phase completes
//   ahbl_hreadyout_o  this slave's ready
//   ahbl_hresp_o      0 OKAY, 1 ERROR
//   ahbl_hrdata_o     read data, little-endian byte lanes
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | ready high, OKAY; final cycle of any OKAY data phase
// WAIT  | OKAY data phase stalled, wait_cnt counts down to 1
// ERR1  | first ERROR cycle, ready low
// ERR2  | second ERROR cycle, ready high; a new transfer may be accepted
// ---------------------------------------------------------------------------
module ahbl_sram_resp #(
  parameter int    ADDR_WIDTH  = 14,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "none"
) (
  input  logic        clk_i,
  input  logic        rstn,
  input  logic        ahbl_hsel_i,
  input  logic [31:0] ahbl_haddr_i,
  input  logic [1:0]  ahbl_htrans_i,
  input  logic        ahbl_hwrite_i,
  input  logic [2:0]  ahbl_hsize_i,
  input  logic [2:0]  ahbl_hburst_i,
  input  logic        ahbl_hready_i,
  input  logic [31:0] ahbl_hwdata_i,
  output logic        ahbl_hreadyout_o,
  output logic        ahbl_hresp_o,
  output logic [31:0] ahbl_hrdata_o
);

  localparam int         IDX_W   = ADDR_WIDTH - 2;
  localparam int         DEPTH   = 1 << IDX_W;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         wait_cnt;
  logic               hreadyout_q;
  logic               hresp_q;
  logic [31:0]        hrdata_q;

  // Legal write whose data phase is in flight; committed when it completes.
  logic               wr_pend;
  logic [IDX_W-1:0]   wr_idx;
  logic [3:0]         wr_be;

  logic [31:0]        mem [DEPTH];

  logic               can_accept;
  logic               accept;
  logic               illegal;
  logic               commit;
  logic               fwd;
  logic [1:0]         addr_lo;
  logic [IDX_W-1:0]   addr_idx;
  logic [3:0]         be_next;
  logic [31:0]        rd_word;
  logic [31:0]        rd_merged;

  // Upper address bits, burst type and htrans[0] carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{ahbl_hburst_i, ahbl_htrans_i[0], ahbl_haddr_i[31:ADDR_WIDTH]};

  always_comb begin
    addr_lo    = ahbl_haddr_i[1:0];
    addr_idx   = ahbl_haddr_i[ADDR_WIDTH-1:2];
    // Only IDLE and ERR2 present ready high, so only they can see a new
    // address phase complete.
    can_accept = (state == ST_IDLE) || (state == ST_ERR2);
    accept     = can_accept & ahbl_hsel_i & ahbl_htrans_i[1] & ahbl_hready_i;

    illegal = (ahbl_hsize_i > 3'd2) ||
              ((ahbl_hsize_i == 3'd1) && addr_lo[0]) ||
              ((ahbl_hsize_i == 3'd2) && (addr_lo != 2'd0));

    case (ahbl_hsize_i)
      3'd0:    be_next = 4'b0001 << addr_lo;
      3'd1:    be_next = 4'b0011 << addr_lo;
      default: be_next = 4'b1111;
    endcase

    // A pending write finishes on any edge where we sit in IDLE.
    commit = (state == ST_IDLE) && wr_pend;

    // A read accepted on the same edge a write to the same word commits must
    // see the new bytes, since the RAM array still holds the old word.
    fwd     = commit && (wr_idx == addr_idx);
    rd_word = mem[addr_idx];
    for (int i = 0; i < 4; i++) begin
      rd_merged[8*i +: 8] = (fwd && wr_be[i]) ? ahbl_hwdata_i[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // RAM array: no reset, byte-lane writes.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= ahbl_hwdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
      wr_pend     <= 1'b0;
      wr_idx      <= '0;
      wr_be       <= 4'd0;
    end else begin
      if (commit) wr_pend <= 1'b0;

      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept && illegal) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else if (accept) begin
            wr_pend <= ahbl_hwrite_i;
            wr_idx  <= addr_idx;
            wr_be   <= be_next;
            // Read data is captured at the address-phase edge so it is
            // already stable for the whole data phase, wait states or not.
            if (!ahbl_hwrite_i) hrdata_q <= rd_merged;
            hresp_q <= 1'b0;
            if (WS_LOAD != 4'd0) begin
              state       <= ST_WAIT;
              wait_cnt    <= WS_LOAD;
              hreadyout_q <= 1'b0;
            end else begin
              state       <= ST_IDLE;
              hreadyout_q <= 1'b1;
            end
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ahbl_hreadyout_o = hreadyout_q;
  assign ahbl_hresp_o     = hresp_q;
  assign ahbl_hrdata_o    = hrdata_q;

endmodule

// File: tb/tb_ahbl_sram_resp.sv
// Bench for ahbl_sram_resp: one instance with no wait states and one with
// three, sharing a single master. The byte-array model below tracks what
// each RAM should hold and what each transfer should respond with.
module tb_ahbl_sram_resp;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rstn;
  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_force;

  logic [1:0]  rdyo;
  logic [1:0]  respo;
  logic [31:0] rdat [2];
  logic        hready_bus;

  assign hready_bus = rdyo[0] & rdyo[1] & hready_force;

  ahbl_sram_resp #(.ADDR_WIDTH(14), .WAIT_STATES(0)) u_ws0 (
    .clk_i            (clk_i),
    .rstn             (rstn),
    .ahbl_hsel_i      (hsel & ~sel),
    .ahbl_haddr_i     (haddr),
    .ahbl_htrans_i    (htrans),
    .ahbl_hwrite_i    (hwrite),
    .ahbl_hsize_i     (hsize),
    .ahbl_hburst_i    (hburst),
    .ahbl_hready_i    (hready_bus),
    .ahbl_hwdata_i    (hwdata),
    .ahbl_hreadyout_o (rdyo[0]),
    .ahbl_hresp_o     (respo[0]),
    .ahbl_hrdata_o    (rdat[0])
  );

  ahbl_sram_resp #(.ADDR_WIDTH(14), .WAIT_STATES(3)) u_ws3 (
    .clk_i            (clk_i),
    .rstn             (rstn),
    .ahbl_hsel_i      (hsel & sel),
    .ahbl_haddr_i     (haddr),
    .ahbl_htrans_i    (htrans),
    .ahbl_hwrite_i    (hwrite),
    .ahbl_hsize_i     (hsize),
    .ahbl_hburst_i    (hburst),
    .ahbl_hready_i    (hready_bus),
    .ahbl_hwdata_i    (hwdata),
    .ahbl_hreadyout_o (rdyo[1]),
    .ahbl_hresp_o     (respo[1]),
    .ahbl_hrdata_o    (rdat[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: one byte array per instance, 16 KiB each.
  logic [7:0] mem_m [2][16384];

  // Transfer currently in its data phase.
  bit          p_valid = 0;
  bit          p_wr    = 0;
  bit          p_err   = 0;
  int          p_sel   = 0;
  logic [31:0] p_addr  = 0;
  logic [31:0] p_wdata = 0;
  logic [2:0]  p_size  = 0;
  logic [31:0] last_rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] sz, input logic [31:0] a);
    if (sz > 3'd2) return 1'b0;
    return (a % (32'd1 << sz)) == 32'd0;
  endfunction

  function automatic logic [31:0] model_word(input int s, input logic [31:0] a);
    int b;
    b = int'(a & 32'h3FFC);
    return {mem_m[s][b+3], mem_m[s][b+2], mem_m[s][b+1], mem_m[s][b]};
  endfunction

  task automatic model_write(input int s, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    for (int b = 0; b < (1 << sz); b++) begin
      int ba;
      ba = int'((a + 32'(b)) & 32'h3FFF);
      mem_m[s][ba] = wd[8*(ba % 4) +: 8];
    end
  endtask

  // Drive one address phase (or an idle slot when act=0) while completing the
  // data phase of the previous transfer. Called just after a rising edge.
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                      input logic [31:0] wd, input bit act);
    int waits;
    bit done;
    hsel   = act;
    htrans = act ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    hburst = 3'($urandom);
    hwdata = (p_valid && p_wr) ? p_wdata : $urandom;
    waits  = 0;
    done   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (hready_bus) begin
        done = 1;
        break;
      end
      if (p_valid && p_err && waits == 0) check("err_first_resp", 32'(respo[p_sel]), 32'd1);
      waits++;
      @(posedge clk_i); #1;
    end
    check("ready_budget", 32'(done), 32'd1);
    if (p_valid) begin
      check("wait_count", 32'(waits), p_err ? 32'd1 : (p_sel == 1 ? 32'd3 : 32'd0));
      check("resp", 32'(respo[p_sel]), 32'(p_err));
      if (!p_err && p_wr) model_write(p_sel, p_addr, p_size, p_wdata);
      if (!p_err && !p_wr) begin
        last_rd = rdat[p_sel];
        check("rdata", rdat[p_sel], model_word(p_sel, p_addr));
      end
    end
    @(posedge clk_i); #1;
    p_valid = act;
    p_wr    = wr;
    p_sel   = int'(sel);
    p_addr  = a;
    p_size  = sz;
    p_wdata = wd;
    p_err   = !is_legal(sz, a);
  endtask

  task automatic idle();
    xfer(32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;

    rstn = 1'b0; sel = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hwdata = 32'h0; hready_force = 1'b1;

    // Reset values with the clock running.
    repeat (3) @(negedge clk_i);
    check("rst_hreadyout", 32'(rdyo), 32'h3);
    check("rst_hresp", 32'(respo), 32'h0);
    check("rst_hrdata0", rdat[0], 32'h0);
    check("rst_hrdata1", rdat[1], 32'h0);
    @(posedge clk_i); #1;
    rstn = 1'b1;

    // IDLE and BUSY while selected: zero-wait OKAY.
    hsel = 1'b1; htrans = 2'b00;
    @(negedge clk_i);
    check("idle_ready", 32'(rdyo), 32'h3);
    check("idle_resp", 32'(respo), 32'h0);
    @(posedge clk_i); #1;
    htrans = 2'b01;
    @(negedge clk_i);
    check("busy_ready", 32'(rdyo), 32'h3);
    check("busy_resp", 32'(respo), 32'h0);
    @(posedge clk_i); #1;
    hsel = 1'b0; htrans = 2'b00;

    // Back-to-back word write then read, no wait states (forwarding).
    sel = 1'b0;
    xfer(32'h10, 1'b1, 3'd2, 32'h12345678, 1'b1);
    xfer(32'h10, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("fwd_word", last_rd, 32'h12345678);

    // Byte and halfword lanes.
    xfer(32'h20, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1);
    xfer(32'h21, 1'b1, 3'd0, 32'h0000AB00, 1'b1);
    xfer(32'h22, 1'b1, 3'd1, 32'hCDEF0000, 1'b1);
    xfer(32'h20, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("lanes_word", last_rd, 32'hCDEFABFF);

    // Illegal transfers: ERROR, memory untouched.
    xfer(32'h00, 1'b1, 3'd2, 32'hA5A5A5A5, 1'b1);
    xfer(32'h02, 1'b1, 3'd2, 32'h11111111, 1'b1);
    xfer(32'h01, 1'b1, 3'd1, 32'h22222222, 1'b1);
    xfer(32'h00, 1'b1, 3'd3, 32'h33333333, 1'b1);
    xfer(32'h01, 1'b0, 3'd1, 32'h0, 1'b1);
    xfer(32'h00, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("err_unchanged", last_rd, 32'hA5A5A5A5);

    // Aliasing: 0x4000 and 0x0000 are the same word.
    xfer(32'h4000, 1'b1, 3'd2, 32'h0BADF00D, 1'b1);
    xfer(32'h0000, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("alias_word", last_rd, 32'h0BADF00D);

    // Three wait states.
    sel = 1'b1;
    xfer(32'h40, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1);
    xfer(32'h40, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("ws3_word", last_rd, 32'hDEADBEEF);

    // Bus ready held low by someone else: the request must not be taken.
    hready_force = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
    hwdata = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hready_low_no_accept", 32'(rdyo[1]), 32'd1);
      @(posedge clk_i); #1;
    end
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk_i); #1;
    hready_force = 1'b1;
    xfer(32'h40, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("hready_low_mem", last_rd, 32'hDEADBEEF);

    // Reset while a write sits in its wait states.
    xfer(32'h40, 1'b1, 3'd2, 32'h11112222, 1'b1);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h11112222;
    @(posedge clk_i); #1;
    rstn = 1'b0;
    #1;
    check("midrst_hreadyout", 32'(rdyo[1]), 32'd1);
    check("midrst_hresp", 32'(respo[1]), 32'd0);
    check("midrst_hrdata", rdat[1], 32'h0);
    p_valid = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn = 1'b1;
    xfer(32'h40, 1'b0, 3'd2, 32'h0, 1'b1);
    idle();
    check("midrst_mem", last_rd, 32'hDEADBEEF);

    // Randomized traffic on both instances against the byte model.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int w = 0; w < 64; w++) xfer(32'h200 + 32'(4*w), 1'b1, 3'd2, $urandom, 1'b1);
      for (int n = 0; n < 150; n++) begin
        a = 32'h200 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFC000);
        sz = 3'($urandom_range(0, 3));
        xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, $urandom_range(0, 7) != 0);
      end
      idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
